// File: rtl/gate_servo_controller.sv
// -----------------------------------------------------------------------------
// gate_servo_controller
//
// Parking-lot entry barrier. An infrared beam at the gate is synchronized and
// debounced into a car-present flag. A four-state FSM walks the barrier
// through CLOSED -> OPENING -> OPEN -> CLOSING. A servo PWM output drives the
// barrier: the pulse width selects the open or closed angle. A registered
// population count of the free-slot inputs blocks opening when the lot is full.
//
// Ports
//   clock_50MHz     in   sole clock, all state on the rising edge
//   reset           in   asynchronous, active-high, clears all state
//   infrared_input  in   asynchronous beam input, low = car at the gate
//   slot_free       in   [N_SLOTS] bit i high = slot i free
//   open_gate       out  servo PWM drive (registered)
//   gate_state      out  [2] 0 CLOSED, 1 OPENING, 2 OPEN, 3 CLOSING
//   free_count      out  registered number of free slots
//   lot_full        out  registered, high when free_count == 0
// -----------------------------------------------------------------------------
module gate_servo_controller #(
    parameter int N_SLOTS         = 6,
    parameter int PWM_PERIOD_CYC  = 1_500_000,
    parameter int OPEN_PULSE_CYC  = 80_000,
    parameter int CLOSE_PULSE_CYC = 26_000,
    parameter int DEBOUNCE_CYC    = 500_000,
    parameter int MOVE_CYC        = 25_000_000,
    parameter int HOLD_CYC        = 100_000_000
) (
    input  logic                               clock_50MHz,
    input  logic                               reset,
    input  logic                               infrared_input,
    input  logic [N_SLOTS-1:0]                 slot_free,
    output logic                               open_gate,
    output logic [1:0]                         gate_state,
    output logic [$clog2(N_SLOTS+1)-1:0]       free_count,
    output logic                               lot_full
);

    localparam int FCW     = $clog2(N_SLOTS + 1);
    localparam int PW      = $clog2(PWM_PERIOD_CYC + 1);
    localparam int DW      = $clog2(DEBOUNCE_CYC + 1);
    localparam int TMR_MAX = (MOVE_CYC > HOLD_CYC) ? MOVE_CYC : HOLD_CYC;
    localparam int TW      = $clog2(TMR_MAX + 1);

    localparam logic [PW-1:0] PWM_LAST = PW'(PWM_PERIOD_CYC - 1);
    localparam logic [PW-1:0] OPEN_W   = PW'(OPEN_PULSE_CYC);
    localparam logic [PW-1:0] CLOSE_W  = PW'(CLOSE_PULSE_CYC);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 1);
    // Move timer is loaded with MOVE_CYC-1 and the exit happens on the edge
    // that sees zero, so the state lasts exactly MOVE_CYC cycles.
    localparam logic [TW-1:0] MOVE_LD  = TW'(MOVE_CYC - 1);
    localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYC);

    typedef enum logic [1:0] {
        S_CLOSED  = 2'd0,
        S_OPENING = 2'd1,
        S_OPEN    = 2'd2,
        S_CLOSING = 2'd3
    } state_t;

    // Synchronizer carries car-present polarity (beam low = car).
    logic           ir_meta_q;
    logic           ir_sync_q;
    logic [DW-1:0]  deb_cnt_q,  deb_cnt_d;
    logic           car_present_q, car_present_d;
    logic [PW-1:0]  pwm_cnt_q,  pwm_cnt_d;
    logic [PW-1:0]  width_q,    width_d;
    logic           open_gate_q, open_gate_d;
    state_t         state_q,    state_d;
    logic [TW-1:0]  tmr_q,      tmr_d;
    logic [FCW-1:0] free_count_q, free_count_d;
    logic           lot_full_q,   lot_full_d;

    // Debounce: count only while the synchronized value disagrees with the
    // current flag; any agreement clears the count.
    always_comb begin
        car_present_d = car_present_q;
        deb_cnt_d     = '0;
        if (ir_sync_q != car_present_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                car_present_d = ir_sync_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DW'(1);
            end
        end
    end

    // PWM: the width only changes at the wrap, so every pulse is complete.
    // open_gate is registered from the current count, giving exactly
    // width_q high cycles per period.
    always_comb begin
        width_d     = width_q;
        open_gate_d = (pwm_cnt_q < width_q);
        if (pwm_cnt_q == PWM_LAST) begin
            pwm_cnt_d = '0;
            width_d   = (state_q == S_OPENING || state_q == S_OPEN) ? OPEN_W : CLOSE_W;
        end else begin
            pwm_cnt_d = pwm_cnt_q + PW'(1);
        end
    end

    // Population count of free slots.
    always_comb begin
        free_count_d = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            free_count_d = free_count_d + FCW'(slot_free[i]);
        end
        lot_full_d = (free_count_d == '0);
    end

    // Gate FSM. The shared move/hold timer is reloaded on every state entry.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            S_CLOSED: begin
                if (car_present_q && (free_count_q != '0)) begin
                    state_d = S_OPENING;
                    tmr_d   = MOVE_LD;
                end
            end
            S_OPENING: begin
                if (tmr_q == '0) begin
                    state_d = S_OPEN;
                    tmr_d   = HOLD_LD;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_OPEN: begin
                if (car_present_q) begin
                    tmr_d = HOLD_LD;
                end else if (tmr_q <= TW'(1)) begin
                    // This edge takes the hold count to zero: leave now so
                    // the gate closes HOLD_CYC cycles after the car clears.
                    state_d = S_CLOSING;
                    tmr_d   = MOVE_LD;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_CLOSING: begin
                // Safety reversal ignores lot_full: never close on a car.
                if (car_present_q) begin
                    state_d = S_OPENING;
                    tmr_d   = MOVE_LD;
                end else if (tmr_q == '0) begin
                    state_d = S_CLOSED;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: begin
                state_d = S_CLOSED;
                tmr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock_50MHz or posedge reset) begin
        if (reset) begin
            ir_meta_q     <= 1'b0;
            ir_sync_q     <= 1'b0;
            deb_cnt_q     <= '0;
            car_present_q <= 1'b0;
            pwm_cnt_q     <= '0;
            width_q       <= CLOSE_W;
            open_gate_q   <= 1'b0;
            state_q       <= S_CLOSED;
            tmr_q         <= '0;
            free_count_q  <= '0;
            lot_full_q    <= 1'b1;
        end else begin
            ir_meta_q     <= ~infrared_input;
            ir_sync_q     <= ir_meta_q;
            deb_cnt_q     <= deb_cnt_d;
            car_present_q <= car_present_d;
            pwm_cnt_q     <= pwm_cnt_d;
            width_q       <= width_d;
            open_gate_q   <= open_gate_d;
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            free_count_q  <= free_count_d;
            lot_full_q    <= lot_full_d;
        end
    end

    assign open_gate  = open_gate_q;
    assign gate_state = state_q;
    assign free_count = free_count_q;
    assign lot_full   = lot_full_q;

endmodule

// File: tb/tb_gate_servo_controller.sv
// -----------------------------------------------------------------------------
// tb_gate_servo_controller
//
// Self-checking bench for gate_servo_controller with small timing parameters
// (PWM 100, OPEN 8, CLOSE 3, DEBOUNCE 4, MOVE 200, HOLD 50, 6 slots).
// Scenario tasks push expected gate_state transitions (state, cycle) into a
// queue as they drive the beam; a monitor pops and compares each transition
// it sees. The monitor also records open_gate per cycle so tasks can count
// pulse widths over whole PWM periods, and it checks that every complete
// pulse is either the open or the close width.
// -----------------------------------------------------------------------------
module tb_gate_servo_controller;

    localparam int NS   = 6;
    localparam int PER  = 100;
    localparam int OPW  = 8;
    localparam int CLW  = 3;
    localparam int HMAX = 8192;

    logic          clk = 1'b0;
    logic          rst;
    logic          ir;
    logic [NS-1:0] slots;
    logic          open_gate;
    logic [1:0]    gate_state;
    logic [2:0]    free_count;
    logic          lot_full;

    typedef struct {
        logic [1:0] st;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         cyc      = 0;
    int         total    = 0;
    int         bad      = 0;
    int         pwm_base = 0;
    int         run      = 0;
    bit         mon_en   = 1'b0;
    logic [1:0] prev_state = 2'd0;
    bit         hist [0:HMAX-1];

    gate_servo_controller #(
        .N_SLOTS        (NS),
        .PWM_PERIOD_CYC (PER),
        .OPEN_PULSE_CYC (OPW),
        .CLOSE_PULSE_CYC(CLW),
        .DEBOUNCE_CYC   (4),
        .MOVE_CYC       (200),
        .HOLD_CYC       (50)
    ) dut (
        .clock_50MHz    (clk),
        .reset          (rst),
        .infrared_input (ir),
        .slot_free      (slots),
        .open_gate      (open_gate),
        .gate_state     (gate_state),
        .free_count     (free_count),
        .lot_full       (lot_full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples 1 ns after each edge.
    always @(posedge clk) begin
        #1;
        if (cyc < HMAX) hist[cyc] = open_gate;
        if (mon_en) begin
            if (gate_state !== prev_state) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL state_unexpected: cycle %0d gate_state=%0d, required no change from %0d",
                             cyc, gate_state, prev_state);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (gate_state !== mon_e.st || cyc != mon_e.cyc) begin
                        bad++;
                        $display("FAIL state_transition: got state %0d at cycle %0d, required state %0d at cycle %0d",
                                 gate_state, cyc, mon_e.st, mon_e.cyc);
                    end
                end
                prev_state = gate_state;
            end
            if (rst) begin
                run = 0;
            end else if (open_gate) begin
                run++;
            end else if (run != 0) begin
                total++;
                if (run != CLW && run != OPW) begin
                    bad++;
                    $display("FAIL pulse_width: cycle %0d pulse of %0d cycles, required %0d or %0d",
                             cyc, run, CLW, OPW);
                end
                run = 0;
            end
        end
    end

    // Inputs are driven and outputs read 2 ns after an edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_expected(input int budget);
        int b = 0;
        while (exp_q.size() != 0 && b < budget) begin
            step(1);
            b++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL transition_timeout: %0d transitions pending at cycle %0d, required 0",
                     exp_q.size(), cyc);
            exp_q.delete();
        end
    endtask

    function automatic int count_high(input int a, input int b);
        int n = 0;
        for (int i = a; i < b; i++) begin
            if (i >= 0 && i < HMAX && hist[i]) n++;
        end
        return n;
    endfunction

    function automatic int next_period_start(input int t);
        int d = t - pwm_base;
        if (d <= 0) return pwm_base;
        return pwm_base + ((d + PER - 1) / PER) * PER;
    endfunction

    task automatic test_reset();
        rst   = 1'b1;
        ir    = 1'b1;
        slots = 6'h3F;
        step(5);
        total += 4;
        if (gate_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d, required 0", gate_state); end
        if (open_gate !== 1'b0)  begin bad++; $display("FAIL reset_pwm: got %0b, required 0", open_gate); end
        if (free_count !== 3'd0) begin bad++; $display("FAIL reset_free: got %0d, required 0", free_count); end
        if (lot_full !== 1'b1)   begin bad++; $display("FAIL reset_full: got %0b, required 1", lot_full); end
        rst        = 1'b0;
        pwm_base   = cyc + 1;
        prev_state = 2'd0;
        mon_en     = 1'b1;
        step(1);
        total += 3;
        if (free_count !== 3'd6) begin bad++; $display("FAIL first_free: got %0d, required 6", free_count); end
        if (lot_full !== 1'b0)   begin bad++; $display("FAIL first_full: got %0b, required 0", lot_full); end
        if (open_gate !== 1'b1)  begin bad++; $display("FAIL first_pulse_start: got %0b, required 1", open_gate); end
        step(PER);
        total++;
        if (count_high(pwm_base, pwm_base + PER) != CLW) begin
            bad++;
            $display("FAIL first_period_width: got %0d, required %0d",
                     count_high(pwm_base, pwm_base + PER), CLW);
        end
    endtask

    task automatic test_slot_count();
        logic [NS-1:0] pats [4] = '{6'b100101, 6'b000001, 6'b111110, 6'h3F};
        int prev_n = 6;
        for (int i = 0; i < 4; i++) begin
            slots = pats[i];
            total++;
            if (free_count !== 3'(prev_n)) begin
                bad++;
                $display("FAIL count_latency[%0d]: got %0d before edge, required %0d", i, free_count, prev_n);
            end
            step(1);
            total += 2;
            if (free_count !== 3'($countones(pats[i]))) begin
                bad++;
                $display("FAIL count[%0d]: got %0d, required %0d", i, free_count, $countones(pats[i]));
            end
            if (lot_full !== 1'b0) begin
                bad++;
                $display("FAIL count_full[%0d]: got %0b, required 0", i, lot_full);
            end
            prev_n = $countones(pats[i]);
        end
    endtask

    task automatic test_idle_pwm();
        int s = next_period_start(cyc + 1);
        step(s + PER - cyc);
        total += 3;
        if (count_high(s, s + PER) != CLW) begin
            bad++;
            $display("FAIL idle_width: got %0d, required %0d", count_high(s, s + PER), CLW);
        end
        if (hist[s] !== 1'b1) begin
            bad++;
            $display("FAIL idle_pulse_phase: got %0b at period start, required 1", hist[s]);
        end
        if (gate_state !== 2'd0) begin
            bad++;
            $display("FAIL idle_state: got %0d, required 0", gate_state);
        end
    endtask

    task automatic test_bounce();
        repeat (12) begin
            ir = 1'b0;
            step(3);
            ir = 1'b1;
            step(1);
        end
        step(12);
        total++;
        if (gate_state !== 2'd0) begin
            bad++;
            $display("FAIL bounce_state: got %0d, required 0", gate_state);
        end
    endtask

    task automatic test_lot_full();
        int s;
        slots = '0;
        step(1);
        total += 2;
        if (free_count !== 3'd0) begin bad++; $display("FAIL full_count: got %0d, required 0", free_count); end
        if (lot_full !== 1'b1)   begin bad++; $display("FAIL full_flag: got %0b, required 1", lot_full); end
        ir = 1'b0;
        step(60);
        total++;
        if (gate_state !== 2'd0) begin bad++; $display("FAIL full_state: got %0d, required 0", gate_state); end
        s = next_period_start(cyc);
        step(s + PER - cyc);
        total++;
        if (count_high(s, s + PER) != CLW) begin
            bad++;
            $display("FAIL full_width: got %0d, required %0d", count_high(s, s + PER), CLW);
        end
        ir = 1'b1;
        step(10);
        slots = 6'h3F;
        step(2);
    endtask

    task automatic test_open_hold();
        int k, t, s, m, d, b;
        k = cyc;
        ir = 1'b0;
        exp_q.push_back('{st: 2'd1, cyc: k + 7});
        exp_q.push_back('{st: 2'd2, cyc: k + 207});
        b = 0;
        while (exp_q.size() > 1 && b < 50) begin step(1); b++; end
        t = k + 7;
        wait_expected(300);
        s = next_period_start(t + 2);
        if (cyc < s + PER) step(s + PER - cyc);
        total += 2;
        if (count_high(s, s + PER) != OPW) begin
            bad++;
            $display("FAIL open_width: got %0d, required %0d", count_high(s, s + PER), OPW);
        end
        if (count_high(s - PER, s) != CLW) begin
            bad++;
            $display("FAIL pre_open_width: got %0d, required %0d", count_high(s - PER, s), CLW);
        end
        step(20);
        // Car clears; it comes back 30 cycles after the debounced drop.
        m  = cyc;
        ir = 1'b1;
        d  = m + 6;
        step(d + 24 - cyc);
        ir = 1'b0;
        step(d + 60 - cyc);
        total++;
        if (gate_state !== 2'd2) begin
            bad++;
            $display("FAIL hold_reload: got %0d, required 2", gate_state);
        end
        step(20);
        slots = '0;
        step(2);
        m  = cyc;
        ir = 1'b1;
        exp_q.push_back('{st: 2'd3, cyc: m + 56});
        wait_expected(100);
    endtask

    task automatic test_reversal();
        int c = cyc;
        step(94);
        ir = 1'b0;
        exp_q.push_back('{st: 2'd1, cyc: c + 101});
        exp_q.push_back('{st: 2'd2, cyc: c + 301});
        wait_expected(400);
        total++;
        if (lot_full !== 1'b1) begin
            bad++;
            $display("FAIL reversal_full: got %0b, required 1", lot_full);
        end
    endtask

    task automatic test_reset_mid_open();
        int b = 0;
        while (open_gate !== 1'b1 && b < 2 * PER) begin step(1); b++; end
        total++;
        if (open_gate !== 1'b1) begin
            bad++;
            $display("FAIL mid_open_pulse: got %0b, required 1", open_gate);
        end
        exp_q.push_back('{st: 2'd0, cyc: cyc + 1});
        #1;
        rst = 1'b1;
        #1;
        total += 4;
        if (gate_state !== 2'd0) begin bad++; $display("FAIL async_state: got %0d, required 0", gate_state); end
        if (open_gate !== 1'b0)  begin bad++; $display("FAIL async_pwm: got %0b, required 0", open_gate); end
        if (free_count !== 3'd0) begin bad++; $display("FAIL async_free: got %0d, required 0", free_count); end
        if (lot_full !== 1'b1)   begin bad++; $display("FAIL async_full: got %0b, required 1", lot_full); end
        ir    = 1'b1;
        slots = 6'h3F;
        step(3);
        rst      = 1'b0;
        pwm_base = cyc + 1;
        step(PER + 1);
        total += 2;
        if (count_high(pwm_base, pwm_base + PER) != CLW) begin
            bad++;
            $display("FAIL post_reset_width: got %0d, required %0d",
                     count_high(pwm_base, pwm_base + PER), CLW);
        end
        if (hist[pwm_base] !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_phase: got %0b, required 1", hist[pwm_base]);
        end
        wait_expected(1);
    endtask

    task automatic test_back_to_back();
        int k, m;
        k  = cyc;
        ir = 1'b0;
        exp_q.push_back('{st: 2'd1, cyc: k + 7});
        exp_q.push_back('{st: 2'd2, cyc: k + 207});
        wait_expected(300);
        m  = cyc;
        ir = 1'b1;
        exp_q.push_back('{st: 2'd3, cyc: m + 56});
        exp_q.push_back('{st: 2'd0, cyc: m + 256});
        wait_expected(400);
        step(5);
        total++;
        if (gate_state !== 2'd0) begin
            bad++;
            $display("FAIL closed_again: got %0d, required 0", gate_state);
        end
    endtask

    initial begin
        test_reset();
        test_slot_count();
        test_idle_pwm();
        test_bounce();
        test_lot_full();
        test_open_hold();
        test_reversal();
        test_reset_mid_open();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gate_servo_controller.md
GATE_SERVO_CONTROLLER -- requirements
Module: gate_servo_controller

Parameters
REQ-001 N_SLOTS, 6, number of parking-slot occupancy inputs (1..32).
REQ-002 PWM_PERIOD_CYC, 1_500_000, servo PWM period in clock cycles (33.33 Hz at 50 MHz).
REQ-003 OPEN_PULSE_CYC, 80_000, high time per period commanding the open angle.
REQ-004 CLOSE_PULSE_CYC, 26_000, high time per period commanding the closed angle.
REQ-005 DEBOUNCE_CYC, 500_000, consecutive stable cycles required to change debounced car-presence.
REQ-006 MOVE_CYC, 25_000_000, servo travel time, OPENING or CLOSING to settled.
REQ-007 HOLD_CYC, 100_000_000, time gate stays open after the car clears.

Interface
REQ-008 clock_50MHz  in  1  sole clock; all state on rising edge.
REQ-009 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-010 infrared_input  in  1  asynchronous; low = car at gate.
REQ-011 slot_free  in  N_SLOTS  bit i high = slot i free; quasi-static, sampled every cycle.
REQ-012 open_gate  out  1  servo PWM drive, registered.
REQ-013 gate_state  out  2  0 CLOSED, 1 OPENING, 2 OPEN, 3 CLOSING.
REQ-014 free_count  out  clog2(N_SLOTS+1)  registered population count of slot_free.
REQ-015 lot_full  out  1  registered; high when free_count == 0.

Function
REQ-016 infrared_input SHALL pass a 2-flop synchronizer; car_present SHALL change only after the synchronized value differs from it for DEBOUNCE_CYC consecutive cycles; any bounce restarts the count.
REQ-017 PWM counter SHALL count 0..PWM_PERIOD_CYC-1, wrapping to 0; open_gate high while counter < active pulse width.
REQ-018 Active pulse width SHALL be latched only at counter wrap to 0: OPEN_PULSE_CYC if state is OPENING or OPEN, else CLOSE_PULSE_CYC; no truncated or stretched pulses.
REQ-019 CLOSED -> OPENING when car_present and free_count > 0; with lot_full, the gate stays CLOSED.
REQ-020 OPENING -> OPEN after MOVE_CYC cycles in OPENING.
REQ-021 OPEN: hold counter reloads to HOLD_CYC while car_present; decrements otherwise; -> CLOSING when it reaches 0 with car absent.
REQ-022 CLOSING -> CLOSED after MOVE_CYC cycles; car_present during CLOSING SHALL force -> OPENING with the move counter restarted, regardless of lot_full (safety reversal).
REQ-023 On every state entry, the move/hold counter SHALL be reloaded in that same edge; only one transition per cycle.
REQ-024 free_count/lot_full SHALL update one cycle after slot_free changes; decisions use registered values.

Reset
REQ-025 While reset is high: open_gate=0, gate_state=CLOSED, PWM/move/hold/debounce counters=0, car_present=0, active width=CLOSE_PULSE_CYC, free_count=0, lot_full=1.
REQ-026 Reset asserted mid-OPENING/OPEN SHALL return to CLOSED immediately; after release, first PWM period SHALL start at counter 0 with close width.

Verification (PWM=100, OPEN=8, CLOSE=3, DEBOUNCE=4, MOVE=200, HOLD=50, N_SLOTS=6)
REQ-027 Idle after reset, slot_free=6'h3F -> open_gate high 3 cycles per 100, gate_state=0, free_count=6, lot_full=0.
REQ-028 infrared low held -> car_present after sync+4 cycles, gate_state=1 next edge; width 8 from next period wrap; gate_state=2 after 200 cycles.
REQ-029 infrared low 3 cycles, high 1, repeatedly -> car_present never asserts, gate stays CLOSED.
REQ-030 slot_free=0, car at gate -> lot_full=1, gate_state stays 0, pulses stay width 3.
REQ-031 Car clears in OPEN -> CLOSING 50 cycles after car_present drops; car reappears at cycle 30 -> hold reloads, stays OPEN.
REQ-032 Car detected 100 cycles into CLOSING with slot_free=0 -> OPENING, full 200-cycle move; reset pulse mid-OPEN -> gate_state=0, open_gate=0 asynchronously.
